// File: rtl/instr_loader.sv
// instr_loader: encodes decoded MIPS instruction fields (ADDU, SUBU, ORI, LW,
// SW, BEQ, LUI, J) into 32-bit words and writes one word per accepted request
// into consecutive instruction-memory addresses. Used to preload programs.
module instr_loader #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [ADDR_W-1:0] target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int CW = ADDR_W + 1;   // pointer width (can hold 2^ADDR_W)
    localparam int PW = ADDR_W + 2;   // signed width for the branch offset

    // Control state
    logic [CW-1:0]     r_ptr;
    logic              r_full;
    logic              r_err;

    // Write-port register stage
    logic              r_we_p1;
    logic [ADDR_W-1:0] r_addr_p1;
    logic [31:0]       r_wdata_p1;

    logic                 w_accept;
    logic                 w_legal;
    logic [CW-1:0]        w_ptr_inc;
    logic signed [PW-1:0] w_diff;
    logic signed [15:0]   w_off16;
    logic [25:0]          w_jtgt;
    logic [31:0]          w_enc;

    // Builds the instruction word; fields not used by an opcode are ignored.
    function automatic logic [31:0] f_encode(
        input logic [2:0]  f_op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [15:0] f_imm,
        input logic [15:0] f_off,
        input logic [25:0] f_jt
    );
        logic [31:0] v;
        v = {6'b000010, f_jt};
        case (f_op)
            3'd0:    v = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b100001};
            3'd1:    v = {6'b000000, f_rs, f_rt, f_rd, 5'b00000, 6'b100011};
            3'd2:    v = {6'b001101, f_rs, f_rt, f_imm};
            3'd3:    v = {6'b100011, f_rs, f_rt, f_imm};
            3'd4:    v = {6'b101011, f_rs, f_rt, f_imm};
            3'd5:    v = {6'b000100, f_rs, f_rt, f_off};
            3'd6:    v = {6'b001111, 5'b00000, f_rt, f_imm};
            default: v = {6'b000010, f_jt};
        endcase
        return v;
    endfunction

    assign in_ready  = !reset && !clear && !r_full;
    assign w_accept  = in_valid && in_ready;
    assign w_legal   = !op[3];
    assign w_ptr_inc = r_ptr + CW'(1);

    // BEQ offset is relative to the word after the branch; the signed
    // difference is sign-extended or truncated down to 16 bits.
    assign w_diff  = $signed({2'b00, target}) - $signed({1'b0, w_ptr_inc});
    assign w_off16 = 16'(w_diff);
    assign w_jtgt  = 26'((BASE_ADDR >> 2) + 32'(target));
    assign w_enc   = f_encode(op[2:0], rs, rt, rd, imm, w_off16, w_jtgt);

    // Accept requests: register the write, advance the pointer, track full/err.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we_p1    <= 1'b0;
            r_addr_p1  <= '0;
            r_wdata_p1 <= '0;
            r_ptr      <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_we_p1 <= w_accept && w_legal;
            if (w_accept && w_legal) begin
                r_addr_p1  <= r_ptr[ADDR_W-1:0];
                r_wdata_p1 <= w_enc;
                r_ptr      <= w_ptr_inc;
                r_full     <= w_ptr_inc[ADDR_W];
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
            // Restart keeps the last written address/data on the bus.
            if (clear) begin
                r_ptr  <= '0;
                r_full <= 1'b0;
                r_err  <= 1'b0;
            end
        end
    end

    assign im_we    = r_we_p1;
    assign im_addr  = r_addr_p1;
    assign im_wdata = r_wdata_p1;
    assign count    = r_ptr;
    assign full     = r_full;
    assign err      = r_err;

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: table of encoded instructions plus hand-written
// sequences for illegal ops, clear/reset during a write, and the full boundary.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, in_ready;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [9:0]  target;
    logic        im_we, full, err;
    logic [9:0]  im_addr;
    logic [31:0] im_wdata;
    logic [10:0] count;

    // Small instance (ADDR_W = 2) for the full boundary
    logic        s_clear, s_valid, s_in_ready;
    logic [3:0]  s_op;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [15:0] s_imm;
    logic [1:0]  s_target;
    logic        s_im_we, s_full, s_err;
    logic [1:0]  s_im_addr;
    logic [31:0] s_im_wdata;
    logic [2:0]  s_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_loader #(.ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .target(target), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .count(count), .full(full), .err(err)
    );

    instr_loader #(.ADDR_W(2)) dut_s (
        .clk(clk), .reset(reset), .clear(s_clear), .in_valid(s_valid),
        .in_ready(s_in_ready), .op(s_op), .rs(s_rs), .rt(s_rt), .rd(s_rd),
        .imm(s_imm), .target(s_target), .im_we(s_im_we), .im_addr(s_im_addr),
        .im_wdata(s_im_wdata), .count(s_count), .full(s_full), .err(s_err)
    );

    typedef struct packed {
        logic        rst_first;
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [9:0]  target;
        logic [31:0] exp_wdata;
        logic [9:0]  exp_addr;
    } vec_t;

    vec_t vec [13];

    function automatic vec_t mk(input logic r, input logic [3:0] o,
                                input logic [4:0] a, input logic [4:0] b,
                                input logic [4:0] c, input logic [15:0] im,
                                input logic [9:0] t, input logic [31:0] w,
                                input logic [9:0] ad);
        vec_t v;
        v.rst_first = r; v.op = o; v.rs = a; v.rt = b; v.rd = c;
        v.imm = im; v.target = t; v.exp_wdata = w; v.exp_addr = ad;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] o, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] c,
                         input logic [15:0] im, input logic [9:0] t);
        op = o; rs = a; rt = b; rd = c; imm = im; target = t;
        in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
        op = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0;
        s_clear = 1'b0; s_valid = 1'b0; s_op = '0; s_rs = '0; s_rt = '0;
        s_rd = '0; s_imm = '0; s_target = '0;

        vec[0]  = mk(1'b1, 4'd0, 5'd1,  5'd2,  5'd3,  16'h0000, 10'd0,  32'h0022_1821, 10'd0);
        vec[1]  = mk(1'b1, 4'd2, 5'd0,  5'd1,  5'd7,  16'h1234, 10'd0,  32'h3401_1234, 10'd0);
        vec[2]  = mk(1'b0, 4'd6, 5'd9,  5'd8,  5'd0,  16'hABCD, 10'd0,  32'h3C08_ABCD, 10'd1);
        vec[3]  = mk(1'b0, 4'd3, 5'd29, 5'd8,  5'd0,  16'h0004, 10'd0,  32'h8FA8_0004, 10'd2);
        vec[4]  = mk(1'b0, 4'd4, 5'd29, 5'd8,  5'd0,  16'h0004, 10'd0,  32'hAFA8_0004, 10'd3);
        vec[5]  = mk(1'b1, 4'd0, 5'd0,  5'd0,  5'd1,  16'h0000, 10'd0,  32'h0000_0821, 10'd0);
        vec[6]  = mk(1'b0, 4'd0, 5'd0,  5'd0,  5'd2,  16'h0000, 10'd0,  32'h0000_1021, 10'd1);
        vec[7]  = mk(1'b0, 4'd0, 5'd0,  5'd0,  5'd3,  16'h0000, 10'd0,  32'h0000_1821, 10'd2);
        vec[8]  = mk(1'b0, 4'd0, 5'd0,  5'd0,  5'd4,  16'h0000, 10'd0,  32'h0000_2021, 10'd3);
        vec[9]  = mk(1'b0, 4'd1, 5'd1,  5'd1,  5'd5,  16'h0000, 10'd0,  32'h0021_2823, 10'd4);
        vec[10] = mk(1'b0, 4'd5, 5'd1,  5'd2,  5'd0,  16'h0000, 10'd2,  32'h1022_FFFC, 10'd5);
        vec[11] = mk(1'b0, 4'd7, 5'd31, 5'd31, 5'd31, 16'hFFFF, 10'd4,  32'h0800_0C04, 10'd6);
        vec[12] = mk(1'b0, 4'd5, 5'd3,  5'd4,  5'd0,  16'h0000, 10'd20, 32'h1064_000C, 10'd7);

        // Reset state
        tick();
        check("ready_in_reset", 32'(in_ready), 32'd0);
        tick();
        check("rst_we",    32'(im_we),    32'd0);
        check("rst_addr",  32'(im_addr),  32'd0);
        check("rst_wdata", im_wdata,      32'd0);
        check("rst_count", 32'(count),    32'd0);
        check("rst_full",  32'(full),     32'd0);
        check("rst_err",   32'(err),      32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Table of encodings, back-to-back within each group
        for (int i = 0; i < 13; i++) begin
            if (vec[i].rst_first) begin
                in_valid = 1'b0;
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            drive(vec[i].op, vec[i].rs, vec[i].rt, vec[i].rd, vec[i].imm, vec[i].target);
            tick();
            check($sformatf("v%0d_we", i),    32'(im_we),   32'd1);
            check($sformatf("v%0d_addr", i),  32'(im_addr), 32'(vec[i].exp_addr));
            check($sformatf("v%0d_wdata", i), im_wdata,     vec[i].exp_wdata);
            check($sformatf("v%0d_count", i), 32'(count),   32'(vec[i].exp_addr) + 32'd1);
        end

        // Outputs hold while idle
        in_valid = 1'b0;
        tick();
        check("hold_we",    32'(im_we),   32'd0);
        check("hold_addr",  32'(im_addr), 32'd7);
        check("hold_wdata", im_wdata,     32'h1064_000C);
        check("hold_count", 32'(count),   32'd8);

        // Reset during a write cycle
        drive(4'd0, 5'd0, 5'd0, 5'd6, 16'h0, 10'd0);
        tick();
        check("prerst_we",   32'(im_we),   32'd1);
        check("prerst_addr", 32'(im_addr), 32'd8);
        reset = 1'b1;
        #1;
        check("rst_ready0", 32'(in_ready), 32'd0);
        tick();
        check("postrst_we",    32'(im_we),   32'd0);
        check("postrst_addr",  32'(im_addr), 32'd0);
        check("postrst_wdata", im_wdata,     32'd0);
        check("postrst_count", 32'(count),   32'd0);
        reset = 1'b0;
        in_valid = 1'b0;

        // Illegal op between legal writes
        drive(4'd0, 5'd0, 5'd0, 5'd1, 16'h0, 10'd0);
        tick();
        check("ill_a_we",   32'(im_we),   32'd1);
        check("ill_a_addr", 32'(im_addr), 32'd0);
        drive(4'hF, 5'd1, 5'd2, 5'd3, 16'h5555, 10'd1);
        tick();
        check("ill_we",    32'(im_we),   32'd0);
        check("ill_err",   32'(err),     32'd1);
        check("ill_count", 32'(count),   32'd1);
        check("ill_addr",  32'(im_addr), 32'd0);
        drive(4'd0, 5'd0, 5'd0, 5'd2, 16'h0, 10'd0);
        tick();
        check("ill_b_we",    32'(im_we),   32'd1);
        check("ill_b_addr",  32'(im_addr), 32'd1);
        check("ill_b_wdata", im_wdata,     32'h0000_1021);
        check("ill_b_count", 32'(count),   32'd2);
        check("ill_b_err",   32'(err),     32'd1);
        drive(4'd0, 5'd0, 5'd0, 5'd3, 16'h0, 10'd0);
        tick();
        check("ill_c_addr", 32'(im_addr), 32'd2);
        check("ill_c_err",  32'(err),     32'd1);

        // Clear while a write is on the bus, with a request presented
        clear = 1'b1;
        drive(4'd0, 5'd0, 5'd0, 5'd9, 16'h0, 10'd0);
        #1;
        check("clr_ready0", 32'(in_ready), 32'd0);
        check("clr_bus_we", 32'(im_we),    32'd1);
        tick();
        check("clr_we",    32'(im_we),   32'd0);
        check("clr_count", 32'(count),   32'd0);
        check("clr_full",  32'(full),    32'd0);
        check("clr_err",   32'(err),     32'd0);
        check("clr_addr",  32'(im_addr), 32'd2);
        clear = 1'b0;
        tick();
        check("postclr_we",    32'(im_we),   32'd1);
        check("postclr_addr",  32'(im_addr), 32'd0);
        check("postclr_wdata", im_wdata,     32'h0000_4821);
        check("postclr_count", 32'(count),   32'd1);
        in_valid = 1'b0;

        // Full boundary on the ADDR_W=2 instance, in_valid held high
        s_op = 4'd0; s_rd = 5'd1; s_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("s%0d_we", k),    32'(s_im_we),    (k <= 4) ? 32'd1 : 32'd0);
            check($sformatf("s%0d_count", k), 32'(s_count),    (k <= 4) ? 32'(k) : 32'd4);
            check($sformatf("s%0d_full", k),  32'(s_full),     (k >= 4) ? 32'd1 : 32'd0);
            check($sformatf("s%0d_ready", k), 32'(s_in_ready), (k >= 4) ? 32'd0 : 32'd1);
            if (k <= 4)
                check($sformatf("s%0d_addr", k), 32'(s_im_addr), 32'(k - 1));
            if (k == 1)
                check("s_wdata", s_im_wdata, 32'h0000_0821);
        end
        check("s_err", 32'(s_err), 32'd0);
        s_clear = 1'b1;
        tick();
        check("s_clr_count", 32'(s_count), 32'd0);
        check("s_clr_full",  32'(s_full),  32'd0);
        s_clear = 1'b0;
        tick();
        check("s_restart_we",   32'(s_im_we),   32'd1);
        check("s_restart_addr", 32'(s_im_addr), 32'd0);
        s_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
